// File: rtl/float_to_int.sv
// float_to_int: three-stage pipelined conversion of a packed float
// {sign, exponent, mantissa} into a signed fixed-point integer with
// FRAC_SIZE fractional bits. Truncates toward zero, saturates out-of-range
// values and flags them on overflow. ce=0 freezes every register.
module float_to_int #(
  parameter int MANTISSA_SIZE = 23,
  parameter int EXPONENT_SIZE = 8,
  parameter int INT_SIZE      = 32,
  parameter int FRAC_SIZE     = 0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 ce,
  input  logic                                 inValid,
  input  logic [EXPONENT_SIZE+MANTISSA_SIZE:0] aIn,
  output logic                                 outValid,
  output logic [INT_SIZE-1:0]                  result,
  output logic                                 overflow
);

  localparam int BIAS = (1 << (EXPONENT_SIZE - 1)) - 1;
  localparam int SW   = EXPONENT_SIZE + 2;        // signed shift width
  localparam int SIGW = MANTISSA_SIZE + 1;        // significand with hidden one
  localparam int WW   = SIGW + INT_SIZE;          // headroom for either shift direction

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_UNDER,
    CLS_SAT,
    CLS_NORMAL
  } cls_t;

  // ---------------- stage 1: unpack and classify ----------------
  logic                         in_sign;
  logic [EXPONENT_SIZE-1:0]     in_exp;
  logic [MANTISSA_SIZE-1:0]     in_man;
  logic signed [31:0]           exp_unb;   // e - bias + FRAC_SIZE
  logic signed [SW-1:0]         shift_in;
  cls_t                         cls_in;

  assign in_sign = aIn[EXPONENT_SIZE+MANTISSA_SIZE];
  assign in_exp  = aIn[EXPONENT_SIZE+MANTISSA_SIZE-1:MANTISSA_SIZE];
  assign in_man  = aIn[MANTISSA_SIZE-1:0];

  // Classify the operand; the exact value -2^(INT_SIZE-1) is representable, so it stays NORMAL.
  always_comb begin
    exp_unb  = $signed({{(32-EXPONENT_SIZE){1'b0}}, in_exp}) - BIAS + FRAC_SIZE;
    shift_in = SW'(exp_unb - MANTISSA_SIZE);
    cls_in   = CLS_NORMAL;
    if (in_exp == '0)
      cls_in = CLS_ZERO;
    else if ((&in_exp) ||
             ((exp_unb >= INT_SIZE - 1) &&
              !(in_sign && (in_man == '0) && (exp_unb == INT_SIZE - 1))))
      cls_in = CLS_SAT;
    else if ((exp_unb - MANTISSA_SIZE) <= -(MANTISSA_SIZE + 1))
      cls_in = CLS_UNDER;
  end

  logic                 v1;
  logic                 sign1;
  cls_t                 cls1;
  logic [SIGW-1:0]      sig1;
  logic signed [SW-1:0] shift1;

  // Stage 1 register: capture class, sign, significand and shift amount.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1     <= 1'b0;
      sign1  <= 1'b0;
      cls1   <= CLS_ZERO;
      sig1   <= '0;
      shift1 <= '0;
    end else if (ce) begin
      v1     <= inValid;
      sign1  <= in_sign;
      cls1   <= cls_in;
      sig1   <= {1'b1, in_man};
      shift1 <= shift_in;
    end
  end

  // ---------------- stage 2: align magnitude ----------------
  logic [WW-1:0]       sig_wide;
  logic [INT_SIZE-1:0] mag_next;

  // Shift the significand into integer position; bits shifted out on the right are dropped.
  always_comb begin
    sig_wide = WW'(sig1);
    mag_next = '0;
    if (cls1 == CLS_NORMAL) begin
      if (!shift1[SW-1])
        mag_next = INT_SIZE'(sig_wide << $unsigned(shift1));
      else
        mag_next = INT_SIZE'(sig_wide >> $unsigned(-shift1));
    end
  end

  logic                v2;
  logic                sign2;
  cls_t                cls2;
  logic [INT_SIZE-1:0] mag2;

  // Stage 2 register: magnitude plus the classification carried alongside.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v2    <= 1'b0;
      sign2 <= 1'b0;
      cls2  <= CLS_ZERO;
      mag2  <= '0;
    end else if (ce) begin
      v2    <= v1;
      sign2 <= sign1;
      cls2  <= cls1;
      mag2  <= mag_next;
    end
  end

  // ---------------- stage 3: apply sign / saturate ----------------
  logic [INT_SIZE-1:0] res_next;
  logic                ovf_next;

  // Produce the final two's-complement value; -0 naturally collapses to 0.
  always_comb begin
    res_next = '0;
    ovf_next = 1'b0;
    case (cls2)
      CLS_SAT: begin
        res_next = sign2 ? {1'b1, {(INT_SIZE-1){1'b0}}} : {1'b0, {(INT_SIZE-1){1'b1}}};
        ovf_next = 1'b1;
      end
      CLS_NORMAL: res_next = sign2 ? -mag2 : mag2;
      default: begin
        res_next = '0;
        ovf_next = 1'b0;
      end
    endcase
  end

  // Output register: result, overflow and the valid that qualifies them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outValid <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
    end else if (ce) begin
      outValid <= v2;
      result   <= res_next;
      overflow <= ovf_next;
    end
  end

endmodule

// File: tb/tb_float_to_int.sv
// Directed bench for float_to_int: a default-parameter instance (a) and an
// INT_SIZE=16 / FRAC_SIZE=8 instance (b) sharing clock, reset and ce.
module tb_float_to_int;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic        in_valid_a, in_valid_b;
  logic [31:0] a_in_a, a_in_b;
  logic        out_valid_a, out_valid_b;
  logic [31:0] result_a;
  logic [15:0] result_b;
  logic        overflow_a, overflow_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  float_to_int dut_a (
    .clk(clk), .reset(reset), .ce(ce), .inValid(in_valid_a), .aIn(a_in_a),
    .outValid(out_valid_a), .result(result_a), .overflow(overflow_a)
  );

  float_to_int #(.INT_SIZE(16), .FRAC_SIZE(8)) dut_b (
    .clk(clk), .reset(reset), .ce(ce), .inValid(in_valid_b), .aIn(a_in_b),
    .outValid(out_valid_b), .result(result_b), .overflow(overflow_b)
  );

  // Drive one operand into instance a (sel=0) or b (sel=1) and wait for its result.
  task automatic convert(input bit sel, input logic [31:0] a,
                         output logic [31:0] r, output logic ov, output int lat);
    @(negedge clk);
    ce = 1'b1;
    in_valid_a = !sel;
    in_valid_b = sel;
    a_in_a = a;
    a_in_b = a;
    @(negedge clk);
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    lat = 1;
    while (((sel ? out_valid_b : out_valid_a) !== 1'b1) && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    if ((sel ? out_valid_b : out_valid_a) !== 1'b1) lat = -1;
    r  = sel ? {16'h0000, result_b} : result_a;
    ov = sel ? overflow_b : overflow_a;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ce = 1'b1;
    in_valid_a = 1'b0; in_valid_b = 1'b0;
    a_in_a = 32'h3F800000; a_in_b = 32'h3F800000;
    repeat (3) @(negedge clk);
    n_checks++; if (out_valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_valid_a got %b want 0", out_valid_a); end
    n_checks++; if (result_a !== 32'h0) begin n_fail++; $display("FAIL reset_result_a got %h want 00000000", result_a); end
    n_checks++; if (overflow_a !== 1'b0) begin n_fail++; $display("FAIL reset_ovf_a got %b want 0", overflow_a); end
    n_checks++; if (out_valid_b !== 1'b0) begin n_fail++; $display("FAIL reset_valid_b got %b want 0", out_valid_b); end
    n_checks++; if (result_b !== 16'h0) begin n_fail++; $display("FAIL reset_result_b got %h want 0000", result_b); end
    n_checks++; if (overflow_b !== 1'b0) begin n_fail++; $display("FAIL reset_ovf_b got %b want 0", overflow_b); end
    reset = 1'b0;
    $display("reset: outputs checked, reset released");
  endtask

  task automatic test_single();
    logic [31:0] vin [4];
    logic [31:0] vexp [4];
    logic [31:0] r; logic ov; int lat;
    vin  = '{32'h3F800000, 32'hC0200000, 32'h3F400000, 32'h00000001};
    vexp = '{32'h00000001, 32'hFFFFFFFE, 32'h00000000, 32'h00000000};
    for (int i = 0; i < 4; i++) begin
      convert(1'b0, vin[i], r, ov, lat);
      $display("single: in=%h result=%h ovf=%b latency=%0d", vin[i], r, ov, lat);
      n_checks++; if (r !== vexp[i]) begin n_fail++; $display("FAIL single_result[%0d] got %h want %h", i, r, vexp[i]); end
      n_checks++; if (ov !== 1'b0) begin n_fail++; $display("FAIL single_ovf[%0d] got %b want 0", i, ov); end
      n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL single_latency[%0d] got %0d want 3", i, lat); end
    end
  endtask

  task automatic test_range();
    logic [31:0] vin [4];
    logic [31:0] vexp [4];
    logic        vovf [4];
    logic [31:0] r; logic ov; int lat;
    vin  = '{32'h4EFFFFFF, 32'h4F000000, 32'hCF000000, 32'hCF000001};
    vexp = '{32'h7FFFFF80, 32'h7FFFFFFF, 32'h80000000, 32'h80000000};
    vovf = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      convert(1'b0, vin[i], r, ov, lat);
      $display("range: in=%h result=%h ovf=%b", vin[i], r, ov);
      n_checks++; if (r !== vexp[i]) begin n_fail++; $display("FAIL range_result[%0d] got %h want %h", i, r, vexp[i]); end
      n_checks++; if (ov !== vovf[i]) begin n_fail++; $display("FAIL range_ovf[%0d] got %b want %b", i, ov, vovf[i]); end
    end
  endtask

  task automatic test_special();
    logic [31:0] vin [4];
    logic [31:0] vexp [4];
    logic        vovf [4];
    logic [31:0] r; logic ov; int lat;
    vin  = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h80000000};
    vexp = '{32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h00000000};
    vovf = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      convert(1'b0, vin[i], r, ov, lat);
      $display("special: in=%h result=%h ovf=%b", vin[i], r, ov);
      n_checks++; if (r !== vexp[i]) begin n_fail++; $display("FAIL special_result[%0d] got %h want %h", i, r, vexp[i]); end
      n_checks++; if (ov !== vovf[i]) begin n_fail++; $display("FAIL special_ovf[%0d] got %b want %b", i, ov, vovf[i]); end
    end
  endtask

  task automatic test_frac();
    logic [31:0] vin [3];
    logic [31:0] vexp [3];
    logic        vovf [3];
    logic [31:0] r; logic ov; int lat;
    vin  = '{32'h3FC00000, 32'hC2FE0000, 32'h43000000};
    vexp = '{32'h00000180, 32'h00008100, 32'h00007FFF};
    vovf = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      convert(1'b1, vin[i], r, ov, lat);
      $display("frac: in=%h result=%h ovf=%b latency=%0d", vin[i], r[15:0], ov, lat);
      n_checks++; if (r !== vexp[i]) begin n_fail++; $display("FAIL frac_result[%0d] got %h want %h", i, r, vexp[i]); end
      n_checks++; if (ov !== vovf[i]) begin n_fail++; $display("FAIL frac_ovf[%0d] got %b want %b", i, ov, vovf[i]); end
      n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL frac_latency[%0d] got %0d want 3", i, lat); end
    end
  endtask

  // Ten back-to-back operands with ce low for the two edges after the 4th.
  task automatic test_back_to_back();
    logic [31:0] ops [10];
    logic [31:0] vexp [10];
    logic [31:0] got [10];
    int  n_out = 0;
    int  first_edge = -1;
    int  last_edge = -1;
    logic ce_prev = 1'b0;
    ops  = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
             32'hC0C00000, 32'h40E00000, 32'h41000000, 32'h41100000, 32'hC1200000};
    vexp = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, -32'sd6, 32'd7, 32'd8, 32'd9, -32'sd10};
    for (int i = 0; i < 10; i++) got[i] = 32'h0;
    for (int t = 0; t < 16; t++) begin
      @(negedge clk);
      if (t > 0) begin
        if (ce_prev && out_valid_a === 1'b1) begin
          if (n_out < 10) got[n_out] = result_a;
          if (first_edge < 0) first_edge = t - 1;
          last_edge = t - 1;
          n_out++;
        end
        if (t == 5 || t == 6) begin
          n_checks++;
          if (out_valid_a !== 1'b1 || result_a !== 32'd2) begin
            n_fail++;
            $display("FAIL stream_hold[t=%0d] got valid=%b result=%h want valid=1 result=00000002", t, out_valid_a, result_a);
          end
        end
      end
      if (t < 4) begin
        ce = 1'b1; in_valid_a = 1'b1; a_in_a = ops[t];
      end else if (t < 6) begin
        ce = 1'b0; in_valid_a = 1'b1; a_in_a = 32'h4F000000;
      end else if (t < 12) begin
        ce = 1'b1; in_valid_a = 1'b1; a_in_a = ops[t-2];
      end else begin
        ce = 1'b1; in_valid_a = 1'b0;
      end
      ce_prev = ce;
    end
    in_valid_a = 1'b0;
    ce = 1'b1;
    for (int i = 0; i < 10; i++) begin
      $display("stream: out[%0d] result=%h expected=%h", i, got[i], vexp[i]);
      n_checks++; if (got[i] !== vexp[i]) begin n_fail++; $display("FAIL stream_result[%0d] got %h want %h", i, got[i], vexp[i]); end
    end
    n_checks++; if (n_out !== 10) begin n_fail++; $display("FAIL stream_count got %0d want 10", n_out); end
    n_checks++; if (first_edge !== 2) begin n_fail++; $display("FAIL stream_first_edge got %0d want 2", first_edge); end
    n_checks++; if (last_edge !== 13) begin n_fail++; $display("FAIL stream_last_edge got %0d want 13", last_edge); end
  endtask

  // Reset asserted between edges with three operands in the pipe.
  task automatic test_reset_midstream();
    logic [31:0] r; logic ov; int lat;
    bit leaked = 1'b0;
    @(negedge clk); ce = 1'b1; in_valid_a = 1'b1; a_in_a = 32'h7F800000;
    @(negedge clk); a_in_a = 32'h40000000;
    @(negedge clk); a_in_a = 32'h40400000;
    @(posedge clk);
    #2;
    in_valid_a = 1'b0;
    reset = 1'b1;
    #1;
    $display("reset_mid: valid=%b result=%h ovf=%b after async reset", out_valid_a, result_a, overflow_a);
    n_checks++; if (out_valid_a !== 1'b0) begin n_fail++; $display("FAIL midreset_valid got %b want 0", out_valid_a); end
    n_checks++; if (result_a !== 32'h0) begin n_fail++; $display("FAIL midreset_result got %h want 00000000", result_a); end
    n_checks++; if (overflow_a !== 1'b0) begin n_fail++; $display("FAIL midreset_ovf got %b want 0", overflow_a); end
    @(negedge clk);
    reset = 1'b0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (out_valid_a !== 1'b0) leaked = 1'b1;
    end
    n_checks++; if (leaked) begin n_fail++; $display("FAIL midreset_leak got in-flight operand after release want none"); end
    convert(1'b0, 32'h41000000, r, ov, lat);
    $display("reset_mid: post-release in=41000000 result=%h latency=%0d", r, lat);
    n_checks++; if (r !== 32'd8) begin n_fail++; $display("FAIL midreset_post_result got %h want 00000008", r); end
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL midreset_post_latency got %0d want 3", lat); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_range();
    test_special();
    test_frac();
    test_back_to_back();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/float_to_int.md
Name: float_to_int

Overview:
- Pipelined converter from the team's parameterised float format (sign, exponent, mantissa) to a signed two's-complement fixed-point integer.
- It is the unpacking counterpart to the float arithmetic units: it consumes packed float results and delivers integers to integer datapaths.
- Throughput is one conversion per enabled clock; latency is 3 enabled clocks.
- Rounding is toward zero; out-of-range inputs saturate.

Parameters:
MANTISSA_SIZE, 23, stored mantissa bits
EXPONENT_SIZE, 8, exponent bits; bias = 2^(EXPONENT_SIZE-1)-1
INT_SIZE, 32, width of the signed result
FRAC_SIZE, 0, fractional bits in the result (result = value * 2^FRAC_SIZE); 0 <= FRAC_SIZE < INT_SIZE

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
ce  in  1  clock enable; low freezes the entire pipeline
inValid  in  1  aIn is a valid operand this cycle
aIn  in  1+EXPONENT_SIZE+MANTISSA_SIZE  packed float {sign, exponent, mantissa}
outValid  out  1  result/overflow valid
result  out  INT_SIZE  signed fixed-point result
overflow  out  1  input was out of range or had an all-ones exponent; result is saturated

Behaviour:
- Interface (already decided): one clock, clk; reset is asynchronous and active-high, port reset.
- Reset: all pipeline valid bits clear, outValid=0, result=0, overflow=0. Reset asserted mid-stream discards every in-flight operand. The first outValid after reset release comes 3 enabled clocks after the first accepted inValid.
- ce=0: no register changes, including valid bits and outputs; outputs hold their last value. inValid is sampled only when ce=1.
- Latency: an operand accepted at enabled edge N appears on result/outValid after enabled edge N+2, i.e. 3 enabled edges total. Data registers update on every enabled edge; outValid qualifies the data.
- Stage 1 (unpack/classify):
  - split sign s, exponent e, mantissa m; significand = {1, m} (MANTISSA_SIZE+1 bits).
  - shift = e - bias + FRAC_SIZE - MANTISSA_SIZE, signed, width EXPONENT_SIZE+2.
  - classify:
    - ZERO: e==0. Denormals flush to 0, overflow=0.
    - SAT: e all ones, or e - bias + FRAC_SIZE >= INT_SIZE-1. Exception: the exact value -2^(INT_SIZE-1) (s=1, m=0, e - bias + FRAC_SIZE == INT_SIZE-1) is NORMAL.
    - UNDER: shift <= -(MANTISSA_SIZE+1). The magnitude is below 1 LSB, so the result is 0, overflow=0.
    - NORMAL: everything else.
- Stage 2 (shift):
  - NORMAL: magnitude = significand << shift if shift >= 0, else significand >> -shift. Discarded bits are truncated (round toward zero).
  - The magnitude register is INT_SIZE bits unsigned and never overflows for the NORMAL class.
- Stage 3 (sign/saturate, registered outputs):
  - ZERO/UNDER: result=0, overflow=0.
  - SAT: result = s ? -2^(INT_SIZE-1) : 2^(INT_SIZE-1)-1; overflow=1. NaN follows its sign bit.
  - NORMAL: result = s ? -magnitude : magnitude; overflow=0.
  - -0.0 yields 0.
- Back-to-back: operands are accepted every enabled cycle with no bubbles. Valid bits propagate independently of data, so gaps in inValid give gaps in outValid.

Test Plan:
- Defaults, single operands: 0x3F800000 -> 0x00000001; 0xC0200000 (-2.5) -> 0xFFFFFFFE; 0x3F400000 (0.75) -> 0x00000000; 0x00000001 (denormal) -> 0, overflow=0. Each has outValid exactly 3 cycles after inValid.
- Range edges, defaults: 0x4EFFFFFF -> 0x7FFFFF80, overflow=0; 0x4F000000 (2^31) -> 0x7FFFFFFF, overflow=1; 0xCF000000 (-2^31) -> 0x80000000, overflow=0; 0xCF000001 -> 0x80000000, overflow=1.
- Special inputs: 0x7F800000 (+inf) -> 0x7FFFFFFF, ovf=1; 0xFF800000 -> 0x80000000, ovf=1; 0x7FC00000 (NaN) -> 0x7FFFFFFF, ovf=1; 0x80000000 (-0) -> 0, ovf=0.
- FRAC_SIZE=8, INT_SIZE=16: 0x3FC00000 (1.5) -> 0x0180; 0xC2FE0000 (-127.0) -> 0x8100, ovf=0; 0x43000000 (128.0) -> 0x7FFF, ovf=1.
- Streaming with ce: 10 consecutive operands, ce low for 2 cycles after the 4th. The output sequence must be in order and unchanged, outputs held during the ce-low cycles, and total duration 12+2 cycles.
- Reset mid-stream: assert reset asynchronously (between edges) while 3 operands are in flight. outValid/result/overflow go to 0 immediately, and no in-flight operand ever emerges after release.
